// File: rtl/iddr_rx_packer_if.sv
// iddr_rx_packer_if: sample inputs, control pulses and the packed-word stream of the DDR receive packer
interface iddr_rx_packer_if #(
   parameter int DATA_BITS = 8,
   parameter int PAIRS     = 2
);
   logic [DATA_BITS-1:0]         din_h;
   logic [DATA_BITS-1:0]         din_l;
   logic                         din_en;
   logic                         slip;
   logic                         overflow_clr;
   logic [2*DATA_BITS*PAIRS-1:0] out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         phase;
   logic                         overflow;
   modport master (
      output din_h, din_l, din_en, slip, overflow_clr, out_ready,
      input  out_data, out_valid, phase, overflow
   );
   modport slave (
      input  din_h, din_l, din_en, slip, overflow_clr, out_ready,
      output out_data, out_valid, phase, overflow
   );
endinterface

// File: rtl/iddr_rx_packer.sv
// iddr_rx_packer: phase-aligns IDDR sample pairs, packs them into words and queues them in a FIFO
module iddr_rx_packer #(
   parameter int DATA_BITS  = 8,
   parameter int PAIRS      = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   iddr_rx_packer_if.slave    bus
);
   localparam int PW = 2 * DATA_BITS;
   localparam int WW = PW * PAIRS;
   localparam int IW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [IW-1:0] LAST = IW'(PAIRS - 1);

   logic                 r_phase, r_prev_v, r_pair_v, r_word_v, r_ovf;
   logic [DATA_BITS-1:0] r_prev_l;
   logic [PW-1:0]        r_pair, w_pair;
   logic                 w_pair_v;
   logic [WW-1:0]        r_acc, r_word, w_word;
   logic [IW-1:0]        r_idx;
   logic [WW-1:0]        r_mem [FIFO_DEPTH];
   logic [AW:0]          r_wr, r_rd;
   logic                 w_full, w_empty, w_pop, w_push, w_drop;

   assign w_pair   = r_phase ? {bus.din_h, r_prev_l} : {bus.din_l, bus.din_h};
   assign w_pair_v = bus.din_en & (~r_phase | r_prev_v);
   assign w_empty  = r_wr == r_rd;
   assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop    = ~w_empty & bus.out_ready;
   assign w_push   = r_word_v & (~w_full | w_pop);
   assign w_drop   = r_word_v & w_full & ~w_pop;

   assign bus.out_data  = r_mem[r_rd[AW-1:0]];
   assign bus.out_valid = ~w_empty;
   assign bus.phase     = r_phase;
   assign bus.overflow  = r_ovf;

   // Pair former: phase 1 borrows the previous cycle's falling sample; slip drops the pair in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase  <= 1'b0;
         r_prev_v <= 1'b0;
         r_prev_l <= '0;
         r_pair_v <= 1'b0;
         r_pair   <= '0;
      end else begin
         r_phase  <= r_phase ^ bus.slip;
         r_pair   <= w_pair;
         r_pair_v <= w_pair_v & ~bus.slip;
         r_prev_v <= ~bus.slip & (r_prev_v | bus.din_en);
         if (bus.din_en) r_prev_l <= bus.din_l;
      end
   end

   // Completed word is the accumulator with the final pair dropped into the top slot
   always_comb begin
      w_word = r_acc;
      w_word[WW-PW +: PW] = r_pair;
   end

   // Packer: fills slots LSB-first; slip abandons the partial word, including one completing now
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx    <= '0;
         r_acc    <= '0;
         r_word   <= '0;
         r_word_v <= 1'b0;
      end else begin
         r_word_v <= r_pair_v & ~bus.slip & (r_idx == LAST);
         if (bus.slip) begin
            r_idx <= '0;
            r_acc <= '0;
         end else if (r_pair_v) begin
            r_acc[r_idx*PW +: PW] <= r_pair;
            r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            if (r_idx == LAST) r_word <= w_word;
         end
      end
   end

   // Output FIFO: a full FIFO still accepts when popping in the same cycle; otherwise drop and flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_ovf <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= r_word;
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_ovf <= w_drop | (r_ovf & ~bus.overflow_clr);
      end
   end
endmodule
